// File: rtl/output_unit.sv
// FFT output stage: captures 8-lane x 8-row frames into a ping-pong buffer and
// streams the 64 bins serially in natural order with frame markers.
module output_unit #(
    parameter int WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_valid,
    input  logic [8*WIDTH-1:0] dinre,
    input  logic [8*WIDTH-1:0] dinim,
    output logic [WIDTH-1:0]   doutre,
    output logic [WIDTH-1:0]   doutim,
    output logic               dout_valid,
    output logic [5:0]         dout_index,
    output logic               frame_start,
    output logic               overflow
);
    typedef enum logic {IDLE, READ} state_t;

    // Buffer address is {bank, row}; each entry holds all 8 lanes of one row.
    logic [WIDTH-1:0] mem_re [16][8];
    logic [WIDTH-1:0] mem_im [16][8];

    state_t     state;
    logic [2:0] wr_row;
    logic       wr_bank;
    logic       dropping;
    logic [1:0] full;
    logic       rd_bank;
    logic [5:0] rd_idx;

    logic       wr_drop;
    logic       wr_en;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic       rd_start;
    logic       emit;
    logic [5:0] emit_idx;
    logic [3:0] emit_addr;
    logic       other_full;

    always_comb begin
        wr_drop    = (wr_row == 3'd0) ? full[wr_bank] : dropping;
        wr_en      = din_valid && !wr_drop;
        full_set   = 2'b00;
        full_clr   = 2'b00;
        if (wr_en && wr_row == 3'd7)
            full_set[wr_bank] = 1'b1;
        if (state == READ && rd_idx == 6'd63)
            full_clr[rd_bank] = 1'b1;
        rd_start   = (state == IDLE) && full[rd_bank];
        emit       = rd_start || (state == READ);
        emit_idx   = rd_start ? 6'd0 : rd_idx;
        emit_addr  = {rd_bank, emit_idx[2:0]};
        // The other bank may complete on the very edge this one drains.
        other_full = full[~rd_bank] || full_set[~rd_bank];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_re[{wr_bank, wr_row}][k] <= dinre[k*WIDTH +: WIDTH];
                mem_im[{wr_bank, wr_row}][k] <= dinim[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row   <= 3'd0;
            wr_bank  <= 1'b0;
            dropping <= 1'b0;
            overflow <= 1'b0;
            full     <= 2'b00;
        end else begin
            overflow <= 1'b0;
            full     <= (full & ~full_clr) | full_set;
            if (din_valid) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd0) begin
                    dropping <= full[wr_bank];
                    overflow <= full[wr_bank];
                end
                if (wr_en && wr_row == 3'd7)
                    wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_idx      <= 6'd0;
            doutre      <= '0;
            doutim      <= '0;
            dout_valid  <= 1'b0;
            dout_index  <= 6'd0;
            frame_start <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (full[rd_bank]) begin
                    state  <= READ;
                    rd_idx <= 6'd1;
                end
            end else if (rd_idx == 6'd63) begin
                rd_bank <= ~rd_bank;
                rd_idx  <= 6'd0;
                state   <= other_full ? READ : IDLE;
            end else begin
                rd_idx <= rd_idx + 6'd1;
            end

            dout_valid <= emit;
            if (emit) begin
                doutre      <= mem_re[emit_addr][emit_idx[5:3]];
                doutim      <= mem_im[emit_addr][emit_idx[5:3]];
                dout_index  <= emit_idx;
                frame_start <= (emit_idx == 6'd0);
            end else begin
                frame_start <= 1'b0;
            end
        end
    end
endmodule
